aes_cbc_seq: RTL and testbench

AES_CBC_SEQ -- requirements
Module: aes_cbc_seq

---
 rtl/aes_cbc_seq.sv | 150 +++++++++++++++
 tb/tb_aes_cbc_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_seq.sv
// ============================================================================
// Module   : aes_cbc_seq
// Purpose  : CBC-mode sequencer around an external AES block core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_cbc_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_start,
  input  logic         cfg_encdec,
  input  logic [127:0] cfg_iv,
  output logic         keyed,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_init,
  output logic         core_next,
  output logic         core_encdec,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic         core_result_valid,
  input  logic [127:0] core_result
);

  localparam logic [2:0] S_UNKEYED  = 3'd0;
  localparam logic [2:0] S_KEY_CMD  = 3'd1;
  localparam logic [2:0] S_KEY_WAIT = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_BLK_CMD  = 3'd4;
  localparam logic [2:0] S_BLK_WAIT = 3'd5;

  logic [2:0]   state_q, state_d;
  logic         keyed_q, keyed_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         encdec_q, encdec_d;
  logic [127:0] block_q, block_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] ct_hold_q, ct_hold_d;
  logic         seen_low_q, seen_low_d;
  logic         w_cfg_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_UNKEYED;
      keyed_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      encdec_q    <= 1'b0;
      block_q     <= '0;
      chain_q     <= '0;
      ct_hold_q   <= '0;
      seen_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      keyed_q     <= keyed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      encdec_q    <= encdec_d;
      block_q     <= block_d;
      chain_q     <= chain_d;
      ct_hold_q   <= ct_hold_d;
      seen_low_q  <= seen_low_d;
    end
  end

  assign w_cfg_acc = cfg_start &&
                     ((state_q == S_UNKEYED) || ((state_q == S_READY) && !out_valid_q));

  always_comb begin
    state_d     = state_q;
    keyed_d     = keyed_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    encdec_d    = encdec_q;
    block_d     = block_q;
    chain_d     = chain_q;
    ct_hold_d   = ct_hold_q;
    seen_low_d  = seen_low_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (w_cfg_acc) begin
      chain_d  = cfg_iv;
      encdec_d = cfg_encdec;
      keyed_d  = 1'b0;
      state_d  = S_KEY_CMD;
    end else begin
      case (state_q)
        S_READY: begin
          if (in_valid && !out_valid_q) begin
            block_d = encdec_q ? (in_data ^ chain_q) : in_data;
            if (!encdec_q) ct_hold_d = in_data;
            state_d = S_BLK_CMD;
          end
        end
        S_KEY_CMD: begin
          // A ready level left over from before the command must not count.
          seen_low_d = 1'b0;
          state_d    = S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          if (!core_ready) begin
            seen_low_d = 1'b1;
          end else if (seen_low_q) begin
            keyed_d = 1'b1;
            state_d = S_READY;
          end
        end
        S_BLK_CMD: begin
          seen_low_d = 1'b0;
          state_d    = S_BLK_WAIT;
        end
        S_BLK_WAIT: begin
          if (!core_ready) begin
            seen_low_d = 1'b1;
          end else if (seen_low_q && core_result_valid) begin
            out_data_d  = encdec_q ? core_result : (core_result ^ chain_q);
            chain_d     = encdec_q ? core_result : ct_hold_q;
            out_valid_d = 1'b1;
            state_d     = S_READY;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_READY) && !out_valid_q;
    busy      = (state_q != S_UNKEYED) && (state_q != S_READY);
    core_init = (state_q == S_KEY_CMD);
    core_next = (state_q == S_BLK_CMD);
  end

  assign keyed       = keyed_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign core_encdec = encdec_q;
  assign core_block  = block_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_cbc_seq.sv
// ============================================================================
// Module   : tb_aes_cbc_seq
// Purpose  : Self-checking bench for aes_cbc_seq with a behavioural AES core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_cbc_seq;

  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_start = 1'b0, cfg_encdec = 1'b0;
  logic [127:0] cfg_iv = '0;
  logic         keyed, busy, in_ready, out_valid;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0, out_data;
  logic         core_init, core_next, core_encdec;
  logic [127:0] core_block;
  logic         core_ready, core_result_valid;
  logic [127:0] core_result;

  aes_cbc_seq dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_encdec(cfg_encdec),
    .cfg_iv(cfg_iv), .keyed(keyed), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .core_init(core_init),
    .core_next(core_next), .core_encdec(core_encdec), .core_block(core_block),
    .core_ready(core_ready), .core_result_valid(core_result_valid),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Stand-in AES: the known FIPS-197 pair, otherwise simple keyed permutations.
  function automatic logic [127:0] aes_e(input logic [127:0] x);
    if (x == C_PT) return C_CT;
    return {x[119:0], x[127:120]} ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] aes_d(input logic [127:0] y);
    if (y == C_CT) return C_PT;
    return ~{y[7:0], y[127:8]};
  endfunction

  int           core_lat = 2;
  int           stale_n = 0;
  int           c_st, c_cnt;
  logic         op_next, op_enc;
  logic [127:0] op_blk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
      c_st <= 0; c_cnt <= 0; op_next <= 1'b0; op_enc <= 1'b0; op_blk <= '0;
    end else begin
      case (c_st)
        0: if (core_init || core_next) begin
             op_next <= core_next; op_enc <= core_encdec; op_blk <= core_block;
             if (stale_n > 0) begin c_st <= 1; c_cnt <= stale_n; end
             else begin core_ready <= 1'b0; c_cnt <= core_lat; c_st <= 2; end
           end
        1: if (c_cnt <= 1) begin core_ready <= 1'b0; c_cnt <= core_lat; c_st <= 2; end
           else c_cnt <= c_cnt - 1;
        default: if (c_cnt <= 1) begin
             core_ready <= 1'b1; c_st <= 0;
             if (op_next) begin
               core_result_valid <= 1'b1;
               core_result <= op_enc ? aes_e(op_blk) : aes_d(op_blk);
             end
           end else c_cnt <= c_cnt - 1;
      endcase
    end
  end

  int xfer_cnt = 0;
  int viol = 0;
  always @(posedge clk) if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
  always @(negedge clk) begin
    if (core_init && core_next) viol <= viol + 1;
    if ((core_init || core_next) && !busy) viol <= viol + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference CBC model
  logic         m_enc;
  logic [127:0] m_chain;

  task automatic model_step(input logic [127:0] din, output logic [127:0] exp_out,
                            output logic [127:0] exp_blk);
    if (m_enc) begin
      exp_blk = din ^ m_chain;
      exp_out = aes_e(exp_blk);
      m_chain = exp_out;
    end else begin
      exp_blk = din;
      exp_out = aes_d(din) ^ m_chain;
      m_chain = din;
    end
  endtask

  task automatic configure(input logic enc, input logic [127:0] iv);
    int n;
    cfg_start = 1'b1; cfg_encdec = enc; cfg_iv = iv;
    @(negedge clk);
    cfg_start = 1'b0;
    m_enc = enc; m_chain = iv;
    chk("cfg_keyed_clear", {255'd0, keyed}, 256'd0);
    n = 0;
    while (!keyed && n < 200) begin @(negedge clk); n++; end
    chk("key_done", {255'd0, keyed}, 256'd1);
  endtask

  task automatic send_block(input logic [127:0] din, input int hold,
                            output logic [127:0] got, output logic [127:0] blk,
                            output int wait_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_data = din;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!core_next && n < 20) begin @(negedge clk); n++; end
    blk = core_block;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    wait_cyc = n;
    chk("out_valid_seen", {255'd0, out_valid}, 256'd1);
    got = out_data;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic         cfg;
    logic         enc;
    logic [127:0] iv;
    logic [127:0] din;
    logic [127:0] exp_out;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] got, blk, e_out, e_blk, hold_data, iv;
    int wc, x0;

    vecs[0] = '{1'b1, 1'b1, 128'd0, C_PT,  C_CT,  C_PT};
    vecs[1] = '{1'b0, 1'b1, 128'd0, C_PT2, C_CT,  C_PT};
    vecs[2] = '{1'b1, 1'b0, 128'd0, C_CT,  C_PT,  C_CT};
    vecs[3] = '{1'b0, 1'b0, 128'd0, C_CT,  C_PT2, C_CT};
    m_enc = 1'b0; m_chain = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_idle", {248'd0, keyed, in_ready, out_valid, core_init, core_next, busy,
                       core_encdec, 1'b0}, 256'd0);
    chk("reset_data", {out_data, core_block}, 256'd0);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].cfg) configure(vecs[i].enc, vecs[i].iv);
      send_block(vecs[i].din, i, got, blk, wc);
      model_step(vecs[i].din, e_out, e_blk);
      chk($sformatf("vec%0d_out", i), {128'd0, got}, {128'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_blk", i), {128'd0, blk}, {128'd0, vecs[i].exp_blk});
    end

    // Backpressure with an ignored cfg_start
    configure(1'b1, {4{$urandom}});
    in_data = {4{$urandom}};
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    model_step(in_data, e_out, e_blk);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    hold_data = out_data;
    chk("bp_data", {128'd0, hold_data}, {128'd0, e_out});
    for (int c = 0; c < 20; c++) begin
      chk("bp_hold", {out_data, 124'd0, out_valid, in_ready, core_init, keyed},
          {hold_data, 124'd0, 4'b1001});
      cfg_start = (c == 5); cfg_encdec = 1'b0; cfg_iv = {4{$urandom}};
      @(negedge clk);
    end
    cfg_start = 1'b0;
    x0 = xfer_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_one_xfer", {224'd0, 32'(xfer_cnt - x0)}, 256'd1);
    chk("bp_cfg_ignored", {254'd0, core_encdec, keyed}, 256'd3);

    // Stale core_ready must not complete the block
    stale_n = 3; core_lat = 2;
    in_data = {4{$urandom}};
    send_block(in_data, 0, got, blk, wc);
    model_step(in_data, e_out, e_blk);
    chk("stale_out", {128'd0, got}, {128'd0, e_out});
    chk("stale_wait", {255'd0, wc >= 6}, 256'd1);
    stale_n = 0;

    // cfg_start and in_valid together: configuration wins
    iv = {4{$urandom}};
    cfg_start = 1'b1; cfg_encdec = 1'b0; cfg_iv = iv;
    in_valid = 1'b1; in_data = {4{$urandom}};
    @(negedge clk);
    cfg_start = 1'b0; in_valid = 1'b0;
    m_enc = 1'b0; m_chain = iv;
    chk("cfg_wins", {253'd0, core_init, core_next, keyed}, 256'd4);
    for (int n = 0; n < 200 && !keyed; n++) @(negedge clk);
    in_data = {4{$urandom}};
    send_block(in_data, 1, got, blk, wc);
    model_step(in_data, e_out, e_blk);
    chk("cfg_wins_out", {128'd0, got}, {128'd0, e_out});

    // Randomized traffic against the model
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) configure(1'($urandom), {4{$urandom}});
      core_lat = $urandom_range(1, 5);
      in_data = {4{$urandom}};
      send_block(in_data, $urandom_range(0, 3), got, blk, wc);
      model_step(in_data, e_out, e_blk);
      chk($sformatf("rnd%0d_out", r), {128'd0, got}, {128'd0, e_out});
      chk($sformatf("rnd%0d_blk", r), {128'd0, blk}, {128'd0, e_blk});
    end

    // Reset during BLK_WAIT aborts the block
    in_data = {4{$urandom}};
    core_lat = 5;
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_abort", {252'd0, keyed, out_valid, busy, in_ready}, 256'd0);
    x0 = xfer_cnt;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    chk("rst_no_xfer", {224'd0, 32'(xfer_cnt - x0)}, 256'd0);
    chk("rst_unkeyed", {254'd0, keyed, in_ready}, 256'd0);
    configure(1'b1, 128'd0);
    send_block(C_PT, 0, got, blk, wc);
    model_step(C_PT, e_out, e_blk);
    chk("rst_rekey_out", {128'd0, got}, {128'd0, C_CT});

    chk("cmd_pulses", {224'd0, 32'(viol)}, 256'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
